// File: rtl/selector_n1_scan.sv
// Registered N:1 word selector: manual select by iSel, or self-stepping scan over masked channels.
// Latency: 1 cycle from sampled inputs to oZ/oCh/oValid/oWrap.
// Backpressure: none; a new selection is presented every cycle and the consumer must keep up.
module selector_n1_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [CHANNELS*WIDTH-1:0] iC,
  input  logic [SEL_W-1:0]          iSel,
  input  logic                      iMode,
  input  logic                      iEn,
  input  logic [CHANNELS-1:0]       iChMask,
  output logic [WIDTH-1:0]          oZ,
  output logic [SEL_W-1:0]          oCh,
  output logic                      oValid,
  output logic                      oWrap
);

  // A single-cycle dwell still needs a 1-bit counter that simply stays at zero.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] dwellCnt, dwellCntNext;
  logic [WIDTH-1:0] zNext;
  logic [SEL_W-1:0] chNext;
  logic             validNext, wrapNext;

  logic [SEL_W-1:0] lowestCh, upCh, followCh;
  logic             anyEn, upFound, followWraps, curEnabled;

  // Live data of one channel; indices outside the channel range read as zero.
  function automatic logic [WIDTH-1:0] chanData(input logic [CHANNELS*WIDTH-1:0] c,
                                                input logic [SEL_W-1:0] idx);
    chanData = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == idx) chanData = c[k*WIDTH +: WIDTH];
    end
  endfunction

  // Scan candidates: lowest enabled channel and the next enabled channel above the presented one.
  always_comb begin
    lowestCh   = '0;
    upCh       = '0;
    upFound    = 1'b0;
    curEnabled = 1'b0;
    anyEn      = |iChMask;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (iChMask[k]) lowestCh = SEL_W'(k);
      if (iChMask[k] && (k > int'(oCh))) begin
        upCh    = SEL_W'(k);
        upFound = 1'b1;
      end
      if (SEL_W'(k) == oCh) curEnabled = iChMask[k];
    end
    // Nothing enabled above us means we wrap to the lowest (possibly ourselves).
    followCh    = upFound ? upCh : lowestCh;
    followWraps = !upFound;
  end

  // Mode decode plus next registered selection for whichever mode we are entering.
  always_comb begin
    stateNext    = !iEn ? IDLE : (iMode ? SCAN : MANUAL);
    zNext        = oZ;
    chNext       = oCh;
    validNext    = 1'b0;
    wrapNext     = 1'b0;
    dwellCntNext = '0;
    case (stateNext)
      IDLE: begin
        // Hold data and index, just drop valid.
      end
      MANUAL: begin
        if (int'(iSel) < CHANNELS) begin
          chNext    = iSel;
          zNext     = chanData(iC, iSel);
          validNext = 1'b1;
        end else begin
          zNext = '0;
        end
      end
      default: begin
        if (!anyEn) begin
          zNext = '0;
        end else begin
          validNext = 1'b1;
          if (state != SCAN || !oValid) begin
            // Fresh entry or resuming after an all-zero mask: start at the bottom.
            chNext = lowestCh;
          end else if (!curEnabled || dwellCnt == CNT_W'(DWELL - 1)) begin
            chNext   = followCh;
            wrapNext = followWraps;
          end else begin
            dwellCntNext = dwellCnt + 1'b1;
          end
          zNext = chanData(iC, chNext);
        end
      end
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      dwellCnt <= '0;
      oZ       <= '0;
      oCh      <= '0;
      oValid   <= 1'b0;
      oWrap    <= 1'b0;
    end else begin
      state    <= stateNext;
      dwellCnt <= dwellCntNext;
      oZ       <= zNext;
      oCh      <= chNext;
      oValid   <= validNext;
      oWrap    <= wrapNext;
    end
  end

endmodule

// File: tb/tb_selector_n1_scan.sv
// Bench for selector_n1_scan: scoreboard of model-predicted outputs, checked one cycle later.
// Latency: expected values are queued before each edge and popped just after it.
// Backpressure: none; every clock produces one expected entry.
module tb_selector_n1_scan;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 3;
  localparam int D  = 4;

  logic            iClk = 1'b0;
  logic            iRst;
  logic [N*W-1:0]  iC;
  logic [SW-1:0]   iSel;
  logic            iMode;
  logic            iEn;
  logic [N-1:0]    iChMask;
  logic [W-1:0]    oZ;
  logic [SW-1:0]   oCh;
  logic            oValid;
  logic            oWrap;

  always #5 iClk = ~iClk;

  selector_n1_scan #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW), .DWELL(D)) dut (
    .iClk(iClk), .iRst(iRst), .iC(iC), .iSel(iSel), .iMode(iMode), .iEn(iEn),
    .iChMask(iChMask), .oZ(oZ), .oCh(oCh), .oValid(oValid), .oWrap(oWrap)
  );

  typedef struct packed {
    logic [W-1:0]  z;
    logic [SW-1:0] ch;
    logic          v;
    logic          w;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: mode 0 idle / 1 manual / 2 scan, cycles left on presented channel.
  int         mMode   = 0;
  int         mCh     = 0;
  int         mRemain = 0;
  logic [W-1:0] mZ    = '0;
  bit         mV      = 0;
  bit         mW      = 0;

  task automatic modelStep();
    int en[$];
    int prevMode;
    int nxt;
    prevMode = mMode;
    mW = 0;
    if (iRst) begin
      mMode = 0; mZ = '0; mCh = 0; mV = 0; mRemain = 0;
    end else if (!iEn) begin
      mMode = 0; mV = 0;
    end else if (!iMode) begin
      mMode = 1;
      if (int'(iSel) < N) begin
        mCh = int'(iSel); mZ = iC[mCh*W +: W]; mV = 1;
      end else begin
        mZ = '0; mV = 0;
      end
    end else begin
      mMode = 2;
      for (int k = 0; k < N; k++) if (iChMask[k]) en.push_back(k);
      if (en.size() == 0) begin
        mV = 0; mZ = '0;
      end else begin
        if (prevMode != 2 || !mV) begin
          mCh = en[0]; mRemain = D;
        end else if (!iChMask[mCh] || mRemain == 1) begin
          nxt = -1;
          foreach (en[i]) if (nxt < 0 && en[i] > mCh) nxt = en[i];
          if (nxt < 0) begin
            nxt = en[0]; mW = 1;
          end
          mCh = nxt; mRemain = D;
        end else begin
          mRemain--;
        end
        mV = 1; mZ = iC[mCh*W +: W];
      end
    end
    expQ.push_back(exp_t'{mZ, SW'(mCh), mV, mW});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs are changed on the falling edge; the model predicts what the next rising edge yields.
  task automatic step(input int n);
    repeat (n) begin
      modelStep();
      @(posedge iClk);
      @(negedge iClk);
    end
  endtask

  // Monitor: pop one prediction per rising edge and compare the whole output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge iClk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        total++;
        if ({oZ, oCh, oValid, oWrap} !== e) begin
          bad++;
          $display("FAIL outputs actual z=%h ch=%0d v=%b w=%b required z=%h ch=%0d v=%b w=%b at %0t",
                   oZ, oCh, oValid, oWrap, e.z, e.ch, e.v, e.w, $time);
        end
      end
    end
  end

  initial begin
    iRst = 1'b1; iEn = 1'b0; iMode = 1'b0; iSel = '0; iChMask = '1; iC = 16'h8421;
    @(negedge iClk);
    step(2);
    chk("rst_z", 16'(oZ), 16'h0);
    chk("rst_ch", 16'(oCh), 16'h0);
    chk("rst_valid", 16'(oValid), 16'h0);
    chk("rst_wrap", 16'(oWrap), 16'h0);

    // Manual selection of each channel.
    iRst = 1'b0; iEn = 1'b1; iMode = 1'b0;
    for (int s = 0; s < N; s++) begin
      iSel = SW'(s);
      step(2);
      chk("man_z", 16'(oZ), 16'(1 << s));
      chk("man_ch", 16'(oCh), 16'(s));
      chk("man_valid", 16'(oValid), 16'h1);
    end
    iSel = SW'(5);
    step(2);
    chk("man_oor_valid", 16'(oValid), 16'h0);
    chk("man_oor_z", 16'(oZ), 16'h0);
    chk("man_oor_ch_hold", 16'(oCh), 16'h3);

    // Full-mask scan: 0x4, 1x4, 2x4, 3x4, then wrap to 0.
    iMode = 1'b1; iChMask = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("scan_ch", 16'(oCh), 16'((i / D) % N));
      chk("scan_wrap", 16'(oWrap), 16'(i == 16));
    end

    // Mask 1010: presented channel 0 drops out, then 1x4, 3x4, wrap to 1.
    iChMask = 4'b1010;
    for (int j = 0; j < 12; j++) begin
      step(1);
      chk("alt_ch", 16'(oCh), ((j / D) % 2) != 0 ? 16'h3 : 16'h1);
      chk("alt_z", 16'(oZ), ((j / D) % 2) != 0 ? 16'h8 : 16'h2);
      chk("alt_wrap", 16'(oWrap), 16'(j == 8));
    end

    // Drop presented channel 2 mid-dwell: channel 3 gets a full dwell, then wrap to 0.
    iChMask = 4'b1111;
    step(2);
    chk("pre_drop_ch", 16'(oCh), 16'h2);
    iChMask = 4'b1011;
    for (int k = 0; k < D; k++) begin
      step(1);
      chk("drop_ch", 16'(oCh), 16'h3);
    end
    step(1);
    chk("drop_wrap_ch", 16'(oCh), 16'h0);
    chk("drop_wrap", 16'(oWrap), 16'h1);

    // Empty mask, then a single enabled channel.
    iChMask = 4'b0000;
    step(2);
    chk("empty_valid", 16'(oValid), 16'h0);
    chk("empty_z", 16'(oZ), 16'h0);
    iChMask = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      step(1);
      chk("single_ch", 16'(oCh), 16'h2);
      chk("single_wrap", 16'(oWrap), 16'(k == 4 || k == 8));
    end

    // Reset mid-scan at channel 2, then restart at channel 0.
    iChMask = 4'b1111;
    for (int k = 0; k < 20 && mCh != 2; k++) step(1);
    chk("pre_rst_ch", 16'(oCh), 16'h2);
    iRst = 1'b1;
    step(1);
    chk("midrst_out", 16'({oZ, oCh, oValid, oWrap}), 16'h0);
    iRst = 1'b0;
    step(2);
    chk("post_rst_ch", 16'(oCh), 16'h0);

    // Disable during scan: valid drops, data and index hold.
    iEn = 1'b0;
    step(2);
    chk("idle_valid", 16'(oValid), 16'h0);
    chk("idle_z_hold", 16'(oZ), 16'h1);
    chk("idle_ch_hold", 16'(oCh), 16'h0);

    // Randomised traffic with live-changing channel data.
    for (int i = 0; i < 3000; i++) begin
      iC    = 16'($urandom);
      iEn   = ($urandom_range(0, 19) != 0);
      iMode = ($urandom_range(0, 9) != 0);
      iSel  = SW'($urandom);
      if ($urandom_range(0, 15) == 0) iChMask = N'($urandom);
      iRst  = ($urandom_range(0, 199) == 0);
      step(1);
    end

    chk("queue_drained", 16'(expQ.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
